// File: rtl/load_store_unit.sv
// Load/store unit: single-request initiator for a big-endian, word-wide byte
// memory. Sub-word loads are extracted and extended; sub-word stores are built
// as read-modify-write because the memory always writes a full word.
module load_store_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [31:0] load_data,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [31:0] MEM_BYTES_W = 32'(MEM_BYTES);

    state_t      state_q;
    logic        is_store_q;
    logic        sign_ext_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [31:0] store_data_q;

    logic        bad_align;
    logic        out_of_range;
    logic [31:0] aligned_addr;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext_d;
    logic [31:0] merged_d;

    // Classify the incoming request (alignment and range) from the live inputs.
    always_comb begin
        aligned_addr = {addr[31:2], 2'b00};
        bad_align    = (size == 2'b11) ||
                       (size == 2'b01 && addr[0]) ||
                       (size == 2'b10 && addr[1:0] != 2'b00);
        out_of_range = (aligned_addr + 32'd3) >= MEM_BYTES_W;
    end

    // Lane extraction for loads and lane merge for sub-word stores.
    always_comb begin
        case (off_q)
            2'd0:    byte_lane = mem_read_data[31:24];
            2'd1:    byte_lane = mem_read_data[23:16];
            2'd2:    byte_lane = mem_read_data[15:8];
            default: byte_lane = mem_read_data[7:0];
        endcase
        half_lane = off_q[1] ? mem_read_data[15:0] : mem_read_data[31:16];

        case (size_q)
            2'b00:   load_ext_d = sign_ext_q ? {{24{byte_lane[7]}}, byte_lane}
                                             : {24'd0, byte_lane};
            2'b01:   load_ext_d = sign_ext_q ? {{16{half_lane[15]}}, half_lane}
                                             : {16'd0, half_lane};
            default: load_ext_d = mem_read_data;
        endcase

        merged_d = mem_read_data;
        if (size_q == 2'b00) begin
            case (off_q)
                2'd0:    merged_d[31:24] = store_data_q[7:0];
                2'd1:    merged_d[23:16] = store_data_q[7:0];
                2'd2:    merged_d[15:8]  = store_data_q[7:0];
                default: merged_d[7:0]   = store_data_q[7:0];
            endcase
        end else if (off_q[1]) begin
            merged_d[15:0] = store_data_q[15:0];
        end else begin
            merged_d[31:16] = store_data_q[15:0];
        end
    end

    // Sequencer with registered outputs; reset clears every output at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            is_store_q     <= 1'b0;
            sign_ext_q     <= 1'b0;
            size_q         <= '0;
            off_q          <= '0;
            store_data_q   <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            load_data      <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        is_store_q   <= is_store;
                        sign_ext_q   <= sign_ext;
                        size_q       <= size;
                        off_q        <= addr[1:0];
                        store_data_q <= store_data;
                        mem_address  <= aligned_addr;
                        busy         <= 1'b1;
                        if (bad_align || out_of_range) begin
                            state_q <= S_ERR;
                            done    <= 1'b1;
                            error   <= 1'b1;
                        end else if (is_store && size == 2'b10) begin
                            state_q        <= S_WRITE;
                            mem_write      <= 1'b1;
                            mem_write_data <= store_data;
                        end else begin
                            state_q  <= S_READ;
                            mem_read <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    mem_read <= 1'b0;
                    if (is_store_q) begin
                        state_q        <= S_WRITE;
                        mem_write      <= 1'b1;
                        mem_write_data <= merged_d;
                    end else begin
                        state_q   <= S_DONE;
                        load_data <= load_ext_d;
                        done      <= 1'b1;
                    end
                end
                S_WRITE: begin
                    state_q   <= S_DONE;
                    mem_write <= 1'b0;
                    done      <= 1'b1;
                end
                S_DONE, S_ERR: begin
                    state_q     <= S_IDLE;
                    done        <= 1'b0;
                    error       <= 1'b0;
                    busy        <= 1'b0;
                    mem_address <= '0;
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    error     <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Pipeline-side initiator for the byte-array data memory.
- Accepts one load/store request at a time from the MEM stage and drives the memory's address, write_data, mem_read and mem_write inputs.
- Performs byte and halfword extraction with sign or zero extension on loads.
- Builds sub-word stores as read-modify-write, because the memory always writes a full word.
- Memory byte order is big-endian: the byte at word address +0 is bits 31:24.

Parameters:
MEM_BYTES, 1024, memory size in bytes; any access whose word end address is >= MEM_BYTES is an error.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
req  input  1  request strobe; sampled only in IDLE.
is_store  input  1  1 = store, 0 = load.
size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
sign_ext  input  1  loads only: 1 sign-extends, 0 zero-extends.
addr  input  32  byte address.
store_data  input  32  store value, right-justified for sub-word sizes.
busy  output  1  high whenever the state is not IDLE.
done  output  1  one-cycle completion pulse.
error  output  1  asserted together with done on a rejected request.
load_data  output  32  extended load result; held until the next completed load.
mem_address  output  32  word-aligned address, {addr[31:2],2'b00}.
mem_write_data  output  32  full word to be written.
mem_read  output  1  memory read enable.
mem_write  output  1  memory write enable.
mem_read_data  input  32  combinational read data returned by the memory.

Behaviour:
- Reset (async, high):
  - State goes to IDLE.
  - All outputs go to 0, including load_data, mem_read and mem_write, immediately without waiting for a clock edge.
  - An in-flight operation is abandoned; no write is issued after reset deasserts.
- States: IDLE, READ, WRITE, DONE, ERR.
- Request capture: on the edge where state = IDLE and req = 1, latch is_store, size, sign_ext, addr and store_data. req is ignored in all other states.
- Transitions from IDLE on an accepted request:
  - Misaligned or illegal → ERR. Misaligned means halfword with addr[0]=1, word with addr[1:0]≠0, or size=11.
  - Out of range → ERR. Out of range means {addr[31:2],2'b00}+3 >= MEM_BYTES.
  - Load → READ.
  - Word store → WRITE.
  - Byte or halfword store → READ.
- READ state:
  - Drive mem_read=1 and mem_write=0 for one cycle.
  - At the closing edge, capture mem_read_data.
  - Load → DONE, with load_data registered at that same edge.
  - Sub-word store → WRITE.
- WRITE state:
  - Drive mem_write=1 and mem_read=0 for exactly one cycle, with mem_write_data stable for that cycle.
  - Next state is DONE.
- DONE state: done=1 for one cycle, then IDLE.
- ERR state: done=1 and error=1 for one cycle, then IDLE. No memory access occurs and load_data is unchanged.
- mem_read and mem_write are never high in the same cycle. Both are low in IDLE, DONE and ERR.
- mem_address holds the latched aligned address in every non-IDLE state and is 0 in IDLE.
- Load extraction, with offset o = addr[1:0]:
  - Byte: bits [31-8o : 24-8o].
  - Halfword: o=0 gives bits 31:16; o=2 gives bits 15:0.
  - The result is extended to 32 bits per sign_ext.
- Store merge: replace only the addressed lane(s) of the captured word with store_data[7:0] (byte) or store_data[15:0] (halfword). All other lanes keep their captured value.
- Latency, counted from the accepting edge E0 to the done cycle:
  - Load: done during the cycle after E1.
  - Word store: done during the cycle after E1.
  - Sub-word store: done during the cycle after E2.
  - Error: done during the cycle after E0.
- Back-to-back: a req held high during DONE is not accepted. It is accepted on the first edge after the unit returns to IDLE.

Test Plan:
- Word store then load: sw 0xDEADBEEF at 0x10, then lw 0x10 → exactly one mem_write cycle with mem_write_data=0xDEADBEEF; then load_data=0xDEADBEEF and done 2 cycles after the request edge.
- Byte load extension: memory word at 0x20 = 0x12F4_5678, lb at 0x21 → load_data=0xFFFF_FFF4; lbu at 0x21 → 0x0000_00F4.
- Sub-word read-modify-write: word at 0x30 = 0xAABBCCDD, sh 0x1234 at 0x32 → READ cycle, then mem_write_data=0xAABB1234, done 3 cycles after the request; a subsequent lw 0x30 returns 0xAABB1234.
- Errors:
  - lw at 0x06 → done=error=1 one cycle after the request; mem_read and mem_write never asserted.
  - sw at 0x400 with MEM_BYTES=1024 → same response.
- Reset mid-store: assert reset during the READ state of an sb → all outputs 0 within the same cycle, busy=0, no mem_write pulse, memory word unchanged.
- Busy/protocol check: pulse req continuously across three mixed requests → each completes in order, no request is lost or duplicated, and mem_read & mem_write = 0 in every cycle (assertion).
